vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Generates the 640x480@60 Hz VGA raster from the 50 MHz system clock.
- Drives the DrawX/DrawY pixel coordinates that the colour mapper consumes, plus hs/vs sync and the active-video qualifier for the DAC/HDMI front end.
- It is the coordinate producer at the far end of the colour-mapper interface.
- Also emits frame_start and line_start strobes, which the ball/bullet motion logic uses as its update tick.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  asynchronous, active-high reset
- pixel_clk  out  1  25 MHz pixel clock, Clk/2, registered toggle
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- display_en  out  1  high while (DrawX,DrawY) is inside the visible area
- DrawX  out  10  current pixel column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- line_start  out  1  one-Clk pulse when DrawX becomes 0
- frame_start  out  1  one-Clk pulse when DrawX and DrawY both become 0

Behaviour:
- Interface: one clock, Clk. Reset is asynchronous and active-high. All state is in flops reset by Reset; no other resets.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Both must be ≤ 1024 so they fit the 10-bit counters; this is enforced by an elaboration-time check.
- Reset values: pixel_clk=0, hc=0, vc=0, DrawX=0, DrawY=0, hs=1, vs=1, display_en=0, line_start=0, frame_start=0.
- Pixel tick: internal pix_en flop toggles on every Clk edge; pixel_clk = pix_en. An "advance" happens on a Clk edge where pix_en==1 before the edge, i.e. every 2nd Clk cycle. The first advance after reset release is the 2nd rising edge.
- Horizontal counter hc: on advance, hc = (hc==H_TOTAL-1) ? 0 : hc+1.
- Vertical counter vc: increments only on an advance where hc wraps. vc = (vc==V_TOTAL-1) ? 0 : vc+1.
- DrawX = hc and DrawY = vc, both straight from the counter flops with zero latency.
- hs, vs and display_en are registered. On each advance they are loaded from a decode of the next (hc,vc) values, so they stay cycle-aligned with DrawX/DrawY and have no combinational glitches.
  - hs = 0 iff H_ACTIVE+H_FP ≤ hc_next < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs = 0 iff V_ACTIVE+V_FP ≤ vc_next < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - display_en = (hc_next < H_ACTIVE) && (vc_next < V_ACTIVE).
  - Between advances all three hold their value.
- First pixel after reset: (0,0) is presented with display_en=0 until the first advance. This is intentional; the first frame after reset is not guaranteed clean.
- line_start: asserted for exactly the one Clk cycle following an advance that wrapped hc to 0; 0 otherwise.
- frame_start: same rule, for an advance that wrapped both hc and vc to 0. It coincides with a line_start pulse.
- Neither strobe is asserted by reset itself.
- Reset mid-line or mid-frame: all outputs return to their reset values immediately (asynchronously). Counting restarts from (0,0) after release, with no partial sync pulse carried over.
- Frame period: H_TOTAL·V_TOTAL·2 = 840 000 Clk cycles. Line period: 1600 Clk cycles.

Decomposition:
- Package vga_timing_pkg holds:
  - the eight timing constants (used as parameter defaults);
  - the derived H_TOTAL/V_TOTAL and the sync start/end constants;
  - typedef coord_t = logic [9:0], shared with color_mapper and the ball/bullet modules.
- One sub-module, mod_counter (parameter MODULUS, inputs en/clear, outputs count and wrap). It is instantiated twice: once for hc with en = advance, once for vc with en = hc wrap.

Test Plan:
- Reset, then release; count Clk edges → DrawX goes 0→1 on the 2nd edge after release, 1→2 on the 4th; pixel_clk toggles every Clk.
- Run one line → hs falls on the advance that sets DrawX=656 and rises at DrawX=752 (96 pixels = 192 Clk low); display_en falls at DrawX=640; line_start pulses for one Clk after DrawX=799→0, and DrawY increments there.
- Run a full frame → vs low exactly while DrawY ∈ {490,491} (3200 Clk); display_en never high for DrawY ≥ 480; frame_start pulses once per 840 000 Clk, coincident with DrawX=DrawY=0.
- Wrap check → at DrawX=799, DrawY=524 the next advance gives (0,0); frame_start=1 and line_start=1 in the same cycle; display_en=1.
- Assert Reset asynchronously mid-line at DrawX=700 (hs=0) → hs=1 and DrawX=0 immediately, before the next Clk edge; no strobe on release.
- Scoreboard across 2 frames: display_en high in exactly 640·480 = 307 200 pixel ticks per frame; the hs pulse count per frame is 525.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster timing constants and the shared coordinate type
package vga_timing_pkg;
   typedef logic [9:0] coord_t;
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster coordinates, syncs and strobes from the sync generator to its consumers
interface vga_sync_gen_if;
   import vga_timing_pkg::*;
   logic   pixel_clk;
   logic   hs;
   logic   vs;
   logic   display_en;
   logic   line_start;
   logic   frame_start;
   coord_t DrawX;
   coord_t DrawY;
   modport master (output pixel_clk, hs, vs, display_en, line_start, frame_start, DrawX, DrawY);
   modport slave  (input  pixel_clk, hs, vs, display_en, line_start, frame_start, DrawX, DrawY);
endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo-MODULUS counter; wrap flags an enabled step from MODULUS-1 back to 0
module mod_counter
   import vga_timing_pkg::*;
#(
   parameter int MODULUS = 800
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  logic   clear,
   output coord_t count,
   output logic   wrap
);
   coord_t count_q, count_d;
   always_comb begin
      wrap    = en && (count_q == coord_t'(MODULUS - 1));
      count_d = (clear || wrap) ? '0 : en ? count_q + 10'd1 : count_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end
   assign count = count_q;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster generator; pixel tick is every second Clk, syncs and
// display_en are registered from the next counter values so they align with DrawX/DrawY
module vga_sync_gen #(
   parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int H_FP     = vga_timing_pkg::H_FP,
   parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int H_BP     = vga_timing_pkg::H_BP,
   parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int V_FP     = vga_timing_pkg::V_FP,
   parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int V_BP     = vga_timing_pkg::V_BP
) (
   input logic           Clk,
   input logic           Reset,
   vga_sync_gen_if.master vga
);
   import vga_timing_pkg::*;
   localparam int     HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int     VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam coord_t HA  = coord_t'(H_ACTIVE);
   localparam coord_t VA  = coord_t'(V_ACTIVE);
   localparam coord_t HSB = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HSE = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VSB = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VSE = coord_t'(V_ACTIVE + V_FP + V_SYNC);
   if (HT > 1024 || VT > 1024) begin : g_size_chk
      $error("vga_sync_gen: line/frame totals exceed the 10-bit counters");
   end
   logic   pix_en_q, pix_en_d, hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic   ls_q, ls_d, fs_q, fs_d, h_wrap, v_wrap;
   coord_t hc, vc, hc_n, vc_n;
   mod_counter #(.MODULUS(HT)) u_hc (
      .clk(Clk), .rst(Reset), .en(pix_en_q), .clear(1'b0), .count(hc), .wrap(h_wrap)
   );
   mod_counter #(.MODULUS(VT)) u_vc (
      .clk(Clk), .rst(Reset), .en(h_wrap), .clear(1'b0), .count(vc), .wrap(v_wrap)
   );
   // decode the position the counters will hold after this edge
   always_comb begin
      pix_en_d = ~pix_en_q;
      hc_n     = h_wrap ? '0 : hc + 10'd1;
      vc_n     = v_wrap ? '0 : h_wrap ? vc + 10'd1 : vc;
      hs_d     = pix_en_q ? !(hc_n >= HSB && hc_n < HSE) : hs_q;
      vs_d     = pix_en_q ? !(vc_n >= VSB && vc_n < VSE) : vs_q;
      de_d     = pix_en_q ? (hc_n < HA && vc_n < VA) : de_q;
      ls_d     = h_wrap;
      fs_d     = v_wrap;
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pix_en_q <= 1'b0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         de_q     <= 1'b0;
         ls_q     <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         pix_en_q <= pix_en_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         de_q     <= de_d;
         ls_q     <= ls_d;
         fs_q     <= fs_d;
      end
   end
   assign vga.pixel_clk   = pix_en_q;
   assign vga.hs          = hs_q;
   assign vga.vs          = vs_q;
   assign vga.display_en  = de_q;
   assign vga.line_start  = ls_q;
   assign vga.frame_start = fs_q;
   assign vga.DrawX       = hc;
   assign vga.DrawY       = vc;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of line timing on the full 640x480 raster and
// frame-level timing on a shrunken 15x11 raster (full frames would take 840k Clk)
module tb_vga_sync_gen;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   vga_sync_gen_if vif();
   vga_sync_gen_if sif();
   vga_sync_gen u_dut (.Clk(Clk), .Reset(Reset), .vga(vif));
   // 8+2+3+2 = 15 pixels/line, 6+1+2+2 = 11 lines: hs low at x 10..12, vs low at y 7..8
   vga_sync_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
   ) u_small (.Clk(Clk), .Reset(Reset), .vga(sif));
   always #5 Clk = ~Clk;

   task automatic test_reset;
      int ex[4] = '{0, 1, 1, 2};
      int ep[4] = '{1, 0, 1, 0};
      int ed[4] = '{0, 1, 1, 1};
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      checks++;
      if ({vif.pixel_clk, vif.hs, vif.vs, vif.display_en, vif.line_start, vif.frame_start} !== 6'b011000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 011000",
                  {vif.pixel_clk, vif.hs, vif.vs, vif.display_en, vif.line_start, vif.frame_start});
      end
      checks++;
      if (vif.DrawX !== 10'd0 || vif.DrawY !== 10'd0) begin
         errors++;
         $display("FAIL reset_xy: got %0d,%0d want 0,0", vif.DrawX, vif.DrawY);
      end
      @(negedge Clk);
      Reset = 1'b0;
      for (int e = 0; e < 4; e++) begin
         @(negedge Clk);
         checks++;
         if (vif.DrawX !== 10'(ex[e]) || vif.pixel_clk !== 1'(ep[e]) || vif.display_en !== 1'(ed[e])) begin
            errors++;
            $display("FAIL startup_edge%0d: got x=%0d pclk=%b de=%b want x=%0d pclk=%0d de=%0d",
                     e + 1, vif.DrawX, vif.pixel_clk, vif.display_en, ex[e], ep[e], ed[e]);
         end
      end
   endtask

   task automatic test_line;
      int hs_fall_x = -1, hs_rise_x = -1, de_fall_x = -1, hs_low = 0;
      int ls_cnt = 0, ls_x = -1, ls_y = -1, fs_cnt = 0, tog_bad = 0;
      logic pclk_prev = vif.pixel_clk;
      for (int i = 0; i < 1600; i++) begin
         @(negedge Clk);
         if (vif.pixel_clk === pclk_prev) tog_bad++;
         pclk_prev = vif.pixel_clk;
         if (vif.hs === 1'b0) begin
            hs_low++;
            if (hs_fall_x < 0) hs_fall_x = int'(vif.DrawX);
         end else if (hs_fall_x >= 0 && hs_rise_x < 0) hs_rise_x = int'(vif.DrawX);
         if (vif.display_en === 1'b0 && de_fall_x < 0) de_fall_x = int'(vif.DrawX);
         if (vif.line_start === 1'b1) begin
            ls_cnt++;
            ls_x = int'(vif.DrawX);
            ls_y = int'(vif.DrawY);
         end
         if (vif.frame_start === 1'b1) fs_cnt++;
      end
      checks++;
      if (hs_fall_x != 656) begin errors++; $display("FAIL hs_fall_x: got %0d want 656", hs_fall_x); end
      checks++;
      if (hs_rise_x != 752) begin errors++; $display("FAIL hs_rise_x: got %0d want 752", hs_rise_x); end
      checks++;
      if (hs_low != 192) begin errors++; $display("FAIL hs_low_clks: got %0d want 192", hs_low); end
      checks++;
      if (de_fall_x != 640) begin errors++; $display("FAIL de_fall_x: got %0d want 640", de_fall_x); end
      checks++;
      if (ls_cnt != 1 || ls_x != 0 || ls_y != 1) begin
         errors++;
         $display("FAIL line_start: got cnt=%0d at %0d,%0d want cnt=1 at 0,1", ls_cnt, ls_x, ls_y);
      end
      checks++;
      if (fs_cnt != 0) begin errors++; $display("FAIL no_frame_start: got %0d want 0", fs_cnt); end
      checks++;
      if (tog_bad != 0) begin errors++; $display("FAIL pclk_toggle: got %0d stalls want 0", tog_bad); end
   endtask

   task automatic test_async_reset;
      int n = 0;
      while (vif.DrawX !== 10'd700 && n < 2000) begin
         @(negedge Clk);
         n++;
      end
      checks++;
      if (vif.DrawX !== 10'd700 || vif.hs !== 1'b0) begin
         errors++;
         $display("FAIL reach_x700: got x=%0d hs=%b want x=700 hs=0", vif.DrawX, vif.hs);
      end
      #2;
      Reset = 1'b1;
      #1;
      checks++;
      if (vif.hs !== 1'b1 || vif.DrawX !== 10'd0 || vif.DrawY !== 10'd0 || vif.pixel_clk !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got hs=%b x=%0d y=%0d pclk=%b want 1,0,0,0",
                  vif.hs, vif.DrawX, vif.DrawY, vif.pixel_clk);
      end
      @(negedge Clk);
      Reset = 1'b0;
      for (int e = 0; e < 4; e++) begin
         @(negedge Clk);
         checks++;
         if (vif.line_start !== 1'b0 || vif.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL release_strobe%0d: got ls=%b fs=%b want 0,0", e, vif.line_start, vif.frame_start);
         end
      end
      checks++;
      if (vif.DrawX !== 10'd2 || vif.hs !== 1'b1) begin
         errors++;
         $display("FAIL restart_x: got x=%0d hs=%b want x=2 hs=1", vif.DrawX, vif.hs);
      end
   endtask

   task automatic test_frame;
      int de_cnt[2] = '{0, 0};
      int hs_falls[2] = '{0, 0};
      int vs_low[2] = '{0, 0};
      int fs_cnt = 0, fs_first = -1, fs_last = -1, fs_gap_bad = 0, fs_coinc_bad = 0;
      int vs_bad = 0, de_bad = 0, f;
      logic hs_prev = 1'b1;
      logic in_vs;
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      for (int k = 1; k <= 995; k++) begin
         @(negedge Clk);
         in_vs = (sif.DrawY == 10'd7 || sif.DrawY == 10'd8);
         if (sif.vs !== !in_vs) vs_bad++;
         if (sif.display_en === 1'b1 && sif.DrawY >= 10'd6) de_bad++;
         if (sif.frame_start === 1'b1) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = k;
            else if (k - fs_last != 330) fs_gap_bad++;
            fs_last = k;
            if (sif.line_start !== 1'b1 || sif.DrawX !== 10'd0 || sif.DrawY !== 10'd0) fs_coinc_bad++;
         end
         if (k >= 330 && k < 990) begin
            f = (k - 330) / 330;
            if (sif.display_en === 1'b1) de_cnt[f]++;
            if (hs_prev === 1'b1 && sif.hs === 1'b0) hs_falls[f]++;
            if (sif.vs === 1'b0) vs_low[f]++;
         end
         hs_prev = sif.hs;
      end
      checks++;
      if (fs_cnt != 3 || fs_first != 330) begin
         errors++;
         $display("FAIL frame_start_count: got %0d first at %0d want 3 first at 330", fs_cnt, fs_first);
      end
      checks++;
      if (fs_gap_bad != 0) begin errors++; $display("FAIL frame_period: got %0d bad gaps want 0", fs_gap_bad); end
      checks++;
      if (fs_coinc_bad != 0) begin errors++; $display("FAIL frame_coincide: got %0d bad want 0", fs_coinc_bad); end
      checks++;
      if (vs_bad != 0) begin errors++; $display("FAIL vs_window: got %0d bad clks want 0", vs_bad); end
      checks++;
      if (de_bad != 0) begin errors++; $display("FAIL de_vblank: got %0d bad clks want 0", de_bad); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (de_cnt[i] != 96) begin errors++; $display("FAIL de_count_f%0d: got %0d want 96", i, de_cnt[i]); end
         checks++;
         if (hs_falls[i] != 11) begin errors++; $display("FAIL hs_pulses_f%0d: got %0d want 11", i, hs_falls[i]); end
         checks++;
         if (vs_low[i] != 60) begin errors++; $display("FAIL vs_low_f%0d: got %0d want 60", i, vs_low[i]); end
      end
   endtask

   task automatic test_wrap;
      int n = 0;
      while (!(sif.DrawX === 10'd14 && sif.DrawY === 10'd10) && n < 400) begin
         @(negedge Clk);
         n++;
      end
      n = 0;
      while (sif.DrawX === 10'd14 && n < 4) begin
         @(negedge Clk);
         n++;
      end
      checks++;
      if ({sif.DrawX, sif.DrawY} !== 20'd0 || sif.frame_start !== 1'b1 || sif.line_start !== 1'b1 ||
          sif.display_en !== 1'b1) begin
         errors++;
         $display("FAIL wrap: got x=%0d y=%0d fs=%b ls=%b de=%b want 0,0,1,1,1",
                  sif.DrawX, sif.DrawY, sif.frame_start, sif.line_start, sif.display_en);
      end
      @(negedge Clk);
      checks++;
      if (sif.frame_start !== 1'b0 || sif.line_start !== 1'b0) begin
         errors++;
         $display("FAIL wrap_pulse_width: got fs=%b ls=%b want 0,0", sif.frame_start, sif.line_start);
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_async_reset();
      test_frame();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
